// File: rtl/sync_fifo_flex.sv
// sync_fifo_flex: single-clock parametrised FIFO with fill-level count,
// programmable almost-full/almost-empty thresholds, sticky overflow and
// underflow flags and a synchronous flush.
//
// Optional feature macro: FIFO_FWFT_EN
//   defined   -> first-word-fall-through: rdata shows the head entry while
//                !rempty, and rinc pops it.
//   undefined -> registered read: rdata is loaded on the accepting rinc edge
//                and holds between reads.
//
// Parameters:
//   dw      data width
//   ps      address width, depth = 2**ps
//   AF_LVL  almost_full  when count >= AF_LVL (1..2**ps)
//   AE_LVL  almost_empty when count <= AE_LVL (0..2**ps-1)
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   flush             synchronous clear, beats winc/rinc
//   winc, wdata       write request and data
//   rinc, rdata       read request and data
//   wfull, rempty     full / empty
//   almost_full/empty threshold flags
//   count             entries stored, 0..2**ps
//   overflow          sticky: winc seen while full
//   underflow         sticky: rinc seen while empty
module sync_fifo_flex #(
  parameter int dw     = 8,
  parameter int ps     = 4,
  parameter int AF_LVL = 12,
  parameter int AE_LVL = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          winc,
  input  logic [dw-1:0] wdata,
  input  logic          rinc,
  output logic [dw-1:0] rdata,
  output logic          wfull,
  output logic          rempty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [ps:0]   count,
  output logic          overflow,
  output logic          underflow
);

  localparam int          DEPTH = 1 << ps;
  localparam logic [ps:0] AF_C  = (ps+1)'(AF_LVL);
  localparam logic [ps:0] AE_C  = (ps+1)'(AE_LVL);

  logic [dw-1:0] mem [DEPTH];
  logic [ps:0]   wptr, rptr;
  logic [ps-1:0] waddr, raddr;
  logic          wren, rden;

  assign waddr = wptr[ps-1:0];
  assign raddr = rptr[ps-1:0];

  // Flags come only from registered pointers/count, so there is no
  // combinational path from winc/rinc to any status output.
  assign rempty       = (wptr == rptr);
  assign wfull        = (wptr[ps] != rptr[ps]) && (waddr == raddr);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  // Accept decisions use the flags as they stood before the edge; a full
  // FIFO can still pop, and an empty FIFO can still push, in the same cycle.
  assign wren = winc & ~wfull;
  assign rden = rinc & ~rempty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wren) wptr <= wptr + 1'b1;
      if (rden) rptr <= rptr + 1'b1;
      case ({wren, rden})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (winc && wfull)  overflow  <= 1'b1;
      if (rinc && rempty) underflow <= 1'b1;
    end
  end

  // Storage is not reset; stale entries are unreachable once the pointers
  // are cleared, since rempty gates every read.
  always_ff @(posedge clk) begin
    if (wren && !flush) mem[waddr] <= wdata;
  end

`ifdef FIFO_FWFT_EN
  // Head entry falls through; forced to zero while empty so the output never
  // shows stale storage after reset or flush.
  assign rdata = rempty ? '0 : mem[raddr];
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rdata <= '0;
    else if (flush) rdata <= '0;
    else if (rden)  rdata <= mem[raddr];
  end
`endif

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Self-checking bench for sync_fifo_flex (dw=8, ps=4, AF_LVL=12, AE_LVL=2).
// Reference model: a queue of bytes plus sticky flags, updated per clock.
module tb_sync_fifo_flex;

  logic       clk, rst_n, flush, winc, rinc;
  logic [7:0] wdata, rdata;
  logic       wfull, rempty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;

  int pass = 0;
  int total = 0;

  logic [7:0] q[$];
  bit         m_ovf, m_unf;
  logic [7:0] m_rd;

  sync_fifo_flex #(.dw(8), .ps(4), .AF_LVL(12), .AE_LVL(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .winc(winc), .wdata(wdata), .rinc(rinc), .rdata(rdata),
    .wfull(wfull), .rempty(rempty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic model_reset();
    q.delete();
    m_ovf = 0;
    m_unf = 0;
    m_rd  = 8'h00;
  endtask

  // Drive one cycle of stimulus from a negedge, update the model at the
  // posedge, and return at the next negedge with inputs idle.
  task automatic step(input bit w, input logic [7:0] wd, input bit r, input bit f);
    bit full, emp;
    winc = w; wdata = wd; rinc = r; flush = f;
    full = (q.size() == 16);
    emp  = (q.size() == 0);
    @(posedge clk);
    if (f) model_reset();
    else begin
      if (w && full) m_ovf = 1;
      if (r && emp)  m_unf = 1;
      if (r && !emp) m_rd = q.pop_front();
      if (w && !full) q.push_back(wd);
    end
    @(negedge clk);
    winc = 0; rinc = 0; flush = 0;
  endtask

  task automatic test_reset();
    rst_n = 0; flush = 0; winc = 0; rinc = 0; wdata = 0;
    model_reset();
    #12;
    total++; if (count !== 5'd0)       $display("FAIL reset_count got %0d exp 0", count); else pass++;
    total++; if (rempty !== 1'b1)      $display("FAIL reset_rempty got %b exp 1", rempty); else pass++;
    total++; if (wfull !== 1'b0)       $display("FAIL reset_wfull got %b exp 0", wfull); else pass++;
    total++; if (almost_empty !== 1'b1) $display("FAIL reset_ae got %b exp 1", almost_empty); else pass++;
    total++; if (almost_full !== 1'b0) $display("FAIL reset_af got %b exp 0", almost_full); else pass++;
    total++; if ({overflow, underflow} !== 2'b00) $display("FAIL reset_err got %b%b exp 00", overflow, underflow); else pass++;
    total++; if (rdata !== 8'h00)      $display("FAIL reset_rdata got %h exp 00", rdata); else pass++;
    @(negedge clk); rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 16; i++) begin
      step(1, 8'(i), 0, 0);
      total++; if (almost_full !== (i + 1 >= 12)) $display("FAIL fill_af n=%0d got %b exp %b", i + 1, almost_full, (i + 1 >= 12)); else pass++;
      total++; if (wfull !== (i == 15)) $display("FAIL fill_wfull n=%0d got %b exp %b", i + 1, wfull, (i == 15)); else pass++;
    end
    total++; if (count !== 5'd16) $display("FAIL fill_count got %0d exp 16", count); else pass++;
    for (int i = 0; i < 16; i++) begin
`ifdef FIFO_FWFT_EN
      total++; if (rdata !== 8'(i)) $display("FAIL drain_data i=%0d got %h exp %h", i, rdata, 8'(i)); else pass++;
      step(0, 0, 1, 0);
`else
      step(0, 0, 1, 0);
      total++; if (rdata !== 8'(i)) $display("FAIL drain_data i=%0d got %h exp %h", i, rdata, 8'(i)); else pass++;
`endif
    end
    total++; if (rempty !== 1'b1) $display("FAIL drain_rempty got %b exp 1", rempty); else pass++;
    total++; if (count !== 5'd0)  $display("FAIL drain_count got %0d exp 0", count); else pass++;
  endtask

  task automatic test_wrap();
    logic [7:0] exp;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 10; i++) begin
        step(1, 8'($urandom), 0, 0);
        total++; if (wfull !== 1'b0 || rempty !== 1'b0) $display("FAIL wrap_wr_flags r=%0d i=%0d got full=%b empty=%b exp 0 0", r, i, wfull, rempty); else pass++;
      end
      for (int i = 0; i < 10; i++) begin
        exp = q[0];
`ifdef FIFO_FWFT_EN
        total++; if (rdata !== exp) $display("FAIL wrap_data r=%0d i=%0d got %h exp %h", r, i, rdata, exp); else pass++;
        step(0, 0, 1, 0);
`else
        step(0, 0, 1, 0);
        total++; if (rdata !== exp) $display("FAIL wrap_data r=%0d i=%0d got %h exp %h", r, i, rdata, exp); else pass++;
`endif
        total++; if (rempty !== (i == 9)) $display("FAIL wrap_rempty r=%0d i=%0d got %b exp %b", r, i, rempty, (i == 9)); else pass++;
      end
    end
  endtask

  task automatic test_full_simul();
    logic [7:0] exp;
    for (int i = 0; i < 16; i++) step(1, 8'(8'h40 + i), 0, 0);
    step(1, 8'hAA, 1, 0);
    total++; if (count !== 5'd15)   $display("FAIL fullsim_count got %0d exp 15", count); else pass++;
    total++; if (overflow !== 1'b1) $display("FAIL fullsim_ovf got %b exp 1", overflow); else pass++;
    total++; if (underflow !== 1'b0) $display("FAIL fullsim_unf got %b exp 0", underflow); else pass++;
`ifndef FIFO_FWFT_EN
    total++; if (rdata !== 8'h40) $display("FAIL fullsim_rdata got %h exp 40", rdata); else pass++;
`endif
    for (int i = 0; i < 15; i++) begin
      exp = q[0];
`ifdef FIFO_FWFT_EN
      total++; if (rdata !== exp || rdata === 8'hAA) $display("FAIL fullsim_drain i=%0d got %h exp %h", i, rdata, exp); else pass++;
      step(0, 0, 1, 0);
`else
      step(0, 0, 1, 0);
      total++; if (rdata !== exp || rdata === 8'hAA) $display("FAIL fullsim_drain i=%0d got %h exp %h", i, rdata, exp); else pass++;
`endif
    end
    total++; if (rempty !== 1'b1) $display("FAIL fullsim_empty got %b exp 1", rempty); else pass++;
    step(0, 0, 0, 1);
  endtask

  task automatic test_empty_simul();
    step(1, 8'h55, 1, 0);
    total++; if (count !== 5'd1)     $display("FAIL emptysim_count got %0d exp 1", count); else pass++;
    total++; if (underflow !== 1'b1) $display("FAIL emptysim_unf got %b exp 1", underflow); else pass++;
    total++; if (overflow !== 1'b0)  $display("FAIL emptysim_ovf got %b exp 0", overflow); else pass++;
`ifdef FIFO_FWFT_EN
    total++; if (rdata !== 8'h55) $display("FAIL emptysim_data got %h exp 55", rdata); else pass++;
    step(0, 0, 1, 0);
`else
    step(0, 0, 1, 0);
    total++; if (rdata !== 8'h55) $display("FAIL emptysim_data got %h exp 55", rdata); else pass++;
`endif
    total++; if (rempty !== 1'b1) $display("FAIL emptysim_rempty got %b exp 1", rempty); else pass++;
    step(0, 0, 0, 1);
  endtask

  task automatic test_thresholds();
    for (int n = 1; n <= 12; n++) begin
      step(1, 8'(n), 0, 0);
      if (n <= 3) begin
        total++; if (almost_empty !== (n <= 2)) $display("FAIL thr_ae n=%0d got %b exp %b", n, almost_empty, (n <= 2)); else pass++;
      end
      if (n >= 11) begin
        total++; if (almost_full !== (n >= 12)) $display("FAIL thr_af n=%0d got %b exp %b", n, almost_full, (n >= 12)); else pass++;
      end
    end
    step(0, 0, 0, 1);
  endtask

  task automatic test_flush();
    for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0);
    step(1, 8'hEE, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 0, 1, 0);
    total++; if (count !== 5'd7 || overflow !== 1'b1) $display("FAIL flush_pre got cnt=%0d ovf=%b exp 7 1", count, overflow); else pass++;
    step(1, 8'h99, 0, 1);
    total++; if (count !== 5'd0)    $display("FAIL flush_count got %0d exp 0", count); else pass++;
    total++; if (rempty !== 1'b1)   $display("FAIL flush_rempty got %b exp 1", rempty); else pass++;
    total++; if (overflow !== 1'b0) $display("FAIL flush_ovf got %b exp 0", overflow); else pass++;
`ifndef FIFO_FWFT_EN
    total++; if (rdata !== 8'h00)   $display("FAIL flush_rdata got %h exp 00", rdata); else pass++;
`endif
    step(0, 0, 0, 0);
    total++; if (rempty !== 1'b1 || count !== 5'd0) $display("FAIL flush_nowrite got empty=%b cnt=%0d exp 1 0", rempty, count); else pass++;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0);
    step(1, 8'hEE, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 0, 1, 0);
    winc = 1; wdata = 8'h77;
    #3 rst_n = 0;
    #1;
    total++; if (count !== 5'd0)    $display("FAIL arst_count got %0d exp 0", count); else pass++;
    total++; if (rempty !== 1'b1)   $display("FAIL arst_rempty got %b exp 1", rempty); else pass++;
    total++; if (overflow !== 1'b0) $display("FAIL arst_ovf got %b exp 0", overflow); else pass++;
    model_reset();
    @(negedge clk); winc = 0; rst_n = 1;
    step(0, 0, 1, 0);
    total++; if (underflow !== 1'b1 || rempty !== 1'b1) $display("FAIL arst_stale got unf=%b empty=%b exp 1 1", underflow, rempty); else pass++;
`ifndef FIFO_FWFT_EN
    total++; if (rdata !== 8'h00) $display("FAIL arst_rdata got %h exp 00", rdata); else pass++;
`endif
    step(1, 8'h11, 0, 0);
`ifdef FIFO_FWFT_EN
    total++; if (rdata !== 8'h11) $display("FAIL arst_after got %h exp 11", rdata); else pass++;
    step(0, 0, 1, 0);
`else
    step(0, 0, 1, 0);
    total++; if (rdata !== 8'h11) $display("FAIL arst_after got %h exp 11", rdata); else pass++;
`endif
    step(0, 0, 0, 1);
  endtask

`ifdef FIFO_FWFT_EN
  task automatic test_fwft();
    step(1, 8'h3C, 0, 0);
    total++; if (rdata !== 8'h3C) $display("FAIL fwft_data got %h exp 3c", rdata); else pass++;
    total++; if (rempty !== 1'b0) $display("FAIL fwft_rempty got %b exp 0", rempty); else pass++;
    step(0, 0, 0, 1);
  endtask
`endif

  task automatic test_random();
    bit w, r, f;
    for (int i = 0; i < 600; i++) begin
      // Alternate write-heavy and read-heavy phases to reach both ends.
      if ((i / 50) % 2 == 0) begin w = ($urandom_range(0, 3) != 0); r = ($urandom_range(0, 3) == 0); end
      else                   begin w = ($urandom_range(0, 3) == 0); r = ($urandom_range(0, 3) != 0); end
      f = ($urandom_range(0, 79) == 0);
      step(w, 8'($urandom), r, f);
      total++;
      if (count !== q.size() || wfull !== (q.size() == 16) || rempty !== (q.size() == 0) ||
          almost_full !== (q.size() >= 12) || almost_empty !== (q.size() <= 2) ||
          overflow !== m_ovf || underflow !== m_unf)
        $display("FAIL rand_state i=%0d got cnt=%0d f=%b e=%b af=%b ae=%b ov=%b un=%b exp cnt=%0d ov=%b un=%b",
                 i, count, wfull, rempty, almost_full, almost_empty, overflow, underflow, q.size(), m_ovf, m_unf);
      else pass++;
`ifdef FIFO_FWFT_EN
      if (q.size() != 0) begin
        total++; if (rdata !== q[0]) $display("FAIL rand_data i=%0d got %h exp %h", i, rdata, q[0]); else pass++;
      end
`else
      total++; if (rdata !== m_rd) $display("FAIL rand_data i=%0d got %h exp %h", i, rdata, m_rd); else pass++;
`endif
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_full_simul();
    test_empty_simul();
    test_thresholds();
    test_flush();
    test_async_reset();
`ifdef FIFO_FWFT_EN
    test_fwft();
`endif
    test_random();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
